// File: rtl/opb_select_pipe.sv
// opb_select_pipe: registered operand-B source multiplexer with a 2-entry
// valid/ready skid pipeline. It sits between the register-file B read port and
// the function unit B input.
//
// Parameters:
//   WIDTH        operand/bus width in bits (>= 4)
//   CONST_WIDTH  width of the instruction constant field (1..WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   request present
//   in_ready   block can accept a request (registered, 0 only when both entries full)
//   B_data     register-file B read data
//   CS         instruction constant field
//   MB         source mode: 00 B_data, 01 zero-ext CS, 10 sign-ext CS, 11 forwarded data
//   fwd_data   forwarded ALU result
//   out_valid  Bus_B holds a valid operand
//   out_ready  consumer accepts Bus_B this cycle
//   Bus_B      selected operand
//   Bus_mode   MB value that produced the current Bus_B
//   sel_err    sticky flag: an illegal mode was accepted
//
// Configuration macro OPB_FWD_EN:
//   defined   -> MB=11 selects fwd_data; sel_err is held at 0.
//   undefined -> MB=11 is illegal: stores zero, keeps Bus_mode=11, sets sel_err.
module opb_select_pipe #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned CONST_WIDTH = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       B_data,
   input  logic [CONST_WIDTH-1:0] CS,
   input  logic [1:0]             MB,
   input  logic [WIDTH-1:0]       fwd_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       Bus_B,
   output logic [1:0]             Bus_mode,
   output logic                   sel_err
);

   typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_t;

   state_t             r_state;
   state_t             w_state_d;
   logic [WIDTH-1:0]   r_main_data;
   logic [1:0]         r_main_mode;
   logic [WIDTH-1:0]   r_skid_data;
   logic [1:0]         r_skid_mode;
   logic               r_in_ready;
   logic               r_sel_err;

   logic               w_accept;
   logic               w_consume;
   logic               w_load_main;
   logic               w_load_skid;
   logic               w_main_from_skid;
   logic [WIDTH-1:0]   w_zext;
   logic [WIDTH-1:0]   w_sext;
   logic [WIDTH-1:0]   w_sel_data;
   logic               w_sel_illegal;

   // Constant field extension; a full-width field passes through unchanged.
   if (CONST_WIDTH < WIDTH) begin : g_ext
      assign w_zext = {{(WIDTH-CONST_WIDTH){1'b0}}, CS};
      assign w_sext = {{(WIDTH-CONST_WIDTH){CS[CONST_WIDTH-1]}}, CS};
   end else begin : g_noext
      assign w_zext = CS;
      assign w_sext = CS;
   end

`ifndef OPB_FWD_EN
   // Forwarding path is compiled out; the port stays for interface compatibility.
   logic w_unused_fwd;
   assign w_unused_fwd = ^fwd_data;
`endif

   // Source selection happens at acceptance; only the selected value is stored.
   always_comb begin
      w_sel_data    = '0;
      w_sel_illegal = 1'b0;
      unique case (MB)
         2'b00: w_sel_data = B_data;
         2'b01: w_sel_data = w_zext;
         2'b10: w_sel_data = w_sext;
         2'b11: begin
`ifdef OPB_FWD_EN
            w_sel_data = fwd_data;
`else
            w_sel_data    = '0;
            w_sel_illegal = 1'b1;
`endif
         end
         default: w_sel_data = '0;
      endcase
   end

   assign w_accept  = in_valid & r_in_ready;
   assign out_valid = (r_state != StEmpty);
   assign w_consume = out_valid & out_ready;

   always_comb begin
      w_state_d        = r_state;
      w_load_main      = 1'b0;
      w_load_skid      = 1'b0;
      w_main_from_skid = 1'b0;
      case (r_state)
         StEmpty: begin
            if (w_accept) begin
               w_state_d   = StOne;
               w_load_main = 1'b1;
            end
         end
         StOne: begin
            if (w_accept && w_consume) begin
               w_load_main = 1'b1;
            end else if (w_accept) begin
               w_state_d   = StTwo;
               w_load_skid = 1'b1;
            end else if (w_consume) begin
               w_state_d = StEmpty;
            end
         end
         StTwo: begin
            // in_ready is 0 here, so only a consume can move the state.
            if (w_consume) begin
               w_state_d        = StOne;
               w_load_main      = 1'b1;
               w_main_from_skid = 1'b1;
            end
         end
         default: w_state_d = StEmpty;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= StEmpty;
         r_main_data <= '0;
         r_main_mode <= 2'b00;
         r_skid_data <= '0;
         r_skid_mode <= 2'b00;
         r_in_ready  <= 1'b1;
         r_sel_err   <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         // Registered ready: derived from the next state, not from out_ready.
         r_in_ready <= (w_state_d != StTwo);
         if (w_load_main) begin
            r_main_data <= w_main_from_skid ? r_skid_data : w_sel_data;
            r_main_mode <= w_main_from_skid ? r_skid_mode : MB;
         end
         if (w_load_skid) begin
            r_skid_data <= w_sel_data;
            r_skid_mode <= MB;
         end
         if (w_accept && w_sel_illegal) begin
            r_sel_err <= 1'b1;
         end
      end
   end

   assign in_ready = r_in_ready;
   assign Bus_B    = r_main_data;
   assign Bus_mode = r_main_mode;
   assign sel_err  = r_sel_err;

endmodule
